// File: rtl/sargantana_icache_pkg.sv
// Shared types and default geometry for the instruction-cache memory controller.
// Imported by the controller top and its victim selector.
package sargantana_icache_pkg;

  localparam int DEF_ICACHE_N_WAY = 4;
  localparam int DEF_ADDR_WIDHT   = 7;
  localparam int DEF_TAG_WIDHT    = 44;
  localparam int DEF_WAY_WIDHT    = 256;

  typedef enum logic [1:0] {
    IDLE,
    FLUSH,
    REFILL_RD,
    REFILL_WR
  } icache_ctrl_state_t;

endpackage

// File: rtl/sargantana_icache_victim_sel.sv
// Refill victim selection: first invalid way, else a one-hot round-robin
// pointer that rotates left each time it is used.
module sargantana_icache_victim_sel
  import sargantana_icache_pkg::*;
#(
  parameter int N_WAY = DEF_ICACHE_N_WAY
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_WAY-1:0] valid_bits,
  input  logic             advance,
  output logic [N_WAY-1:0] victim,
  output logic             all_valid
);

  logic [N_WAY-1:0] ptr;
  logic [N_WAY-1:0] first_free;
  logic             found;

  assign all_valid = &valid_bits;

  always_comb begin
    first_free = '0;
    found      = 1'b0;
    for (int i = 0; i < N_WAY; i++) begin
      if (!valid_bits[i] && !found) begin
        first_free[i] = 1'b1;
        found         = 1'b1;
      end
    end
  end

  assign victim = all_valid ? ptr : first_free;

  // Pointer only moves when it actually chose the victim.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= {{(N_WAY-1){1'b0}}, 1'b1};
    end else if (advance && all_valid) begin
      ptr <= {ptr[N_WAY-2:0], ptr[N_WAY-1]};
    end
  end

endmodule

// File: rtl/sargantana_icache_mem_ctrl.sv
// Sequencer/arbiter for the icache memory port: flush > refill > lookup.
// SARGANTANA_ICACHE_FLUSH_ON_RESET_EN: start in FLUSH after reset.
module sargantana_icache_mem_ctrl
  import sargantana_icache_pkg::*;
#(
  parameter int ICACHE_N_WAY = DEF_ICACHE_N_WAY,
  parameter int ADDR_WIDHT   = DEF_ADDR_WIDHT,
  parameter int TAG_WIDHT    = DEF_TAG_WIDHT,
  parameter int WAY_WIDHT    = DEF_WAY_WIDHT
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    flush_req_i,
  output logic                    flush_done_o,
  output logic                    busy_o,
  input  logic                    lookup_valid_i,
  input  logic [ADDR_WIDHT-1:0]   lookup_idx_i,
  output logic                    lookup_ready_o,
  input  logic                    refill_valid_i,
  input  logic [ADDR_WIDHT-1:0]   refill_idx_i,
  input  logic [TAG_WIDHT-1:0]    refill_tag_i,
  input  logic [WAY_WIDHT-1:0]    refill_line_i,
  output logic                    refill_ready_o,
  output logic [ICACHE_N_WAY-1:0] refill_way_o,
  input  logic [ICACHE_N_WAY-1:0] mem_valid_bit_i,
  output logic [ICACHE_N_WAY-1:0] mem_way_req_o,
  output logic                    mem_we_o,
  output logic                    mem_valid_bit_o,
  output logic [WAY_WIDHT-1:0]    mem_cline_o,
  output logic [TAG_WIDHT-1:0]    mem_tag_o,
  output logic [ADDR_WIDHT-1:0]   mem_addr_o
);

`ifdef SARGANTANA_ICACHE_FLUSH_ON_RESET_EN
  localparam icache_ctrl_state_t RST_STATE = FLUSH;
`else
  localparam icache_ctrl_state_t RST_STATE = IDLE;
`endif

  icache_ctrl_state_t     state;
  icache_ctrl_state_t     state_next;
  logic [ADDR_WIDHT-1:0]  counter;
  logic [ADDR_WIDHT-1:0]  counter_next;
  logic                   flush_pend;
  logic                   pend_next;
  logic                   advance;
  logic [ICACHE_N_WAY-1:0] victim;
  logic                   all_valid;

  sargantana_icache_victim_sel #(
    .N_WAY (ICACHE_N_WAY)
  ) u_victim_sel (
    .clk        (clk_i),
    .rst        (rst_i),
    .valid_bits (mem_valid_bit_i),
    .advance    (advance),
    .victim     (victim),
    .all_valid  (all_valid)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= RST_STATE;
      counter    <= '0;
      flush_pend <= 1'b0;
    end else begin
      state      <= state_next;
      counter    <= counter_next;
      flush_pend <= pend_next;
    end
  end

  assign busy_o = (state != IDLE);

  always_comb begin
    state_next      = state;
    counter_next    = counter;
    pend_next       = flush_pend | flush_req_i;
    advance         = 1'b0;
    flush_done_o    = 1'b0;
    lookup_ready_o  = 1'b0;
    refill_ready_o  = 1'b0;
    refill_way_o    = '0;
    mem_way_req_o   = '0;
    mem_we_o        = 1'b0;
    mem_valid_bit_o = 1'b0;
    mem_cline_o     = '0;
    mem_tag_o       = '0;
    mem_addr_o      = '0;
    unique case (state)
      IDLE: begin
        if (flush_pend || flush_req_i) begin
          state_next   = FLUSH;
          counter_next = '0;
          pend_next    = 1'b0;
        end else if (refill_valid_i) begin
          state_next = REFILL_RD;
        end else if (lookup_valid_i) begin
          lookup_ready_o = 1'b1;
          mem_way_req_o  = '1;
          mem_addr_o     = lookup_idx_i;
        end
      end
      FLUSH: begin
        // Requests seen mid-flush are covered by this flush.
        pend_next     = 1'b0;
        mem_way_req_o = '1;
        mem_we_o      = 1'b1;
        mem_addr_o    = counter;
        counter_next  = counter + ADDR_WIDHT'(1);
        if (counter == '1) begin
          flush_done_o = 1'b1;
          state_next   = IDLE;
        end
      end
      REFILL_RD: begin
        mem_way_req_o = '1;
        mem_addr_o    = refill_idx_i;
        state_next    = REFILL_WR;
      end
      REFILL_WR: begin
        advance         = 1'b1;
        mem_way_req_o   = victim;
        mem_we_o        = 1'b1;
        mem_valid_bit_o = 1'b1;
        mem_tag_o       = refill_tag_i;
        mem_cline_o     = refill_line_i;
        mem_addr_o      = refill_idx_i;
        refill_ready_o  = 1'b1;
        refill_way_o    = victim;
        state_next      = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sargantana_icache_mem_ctrl.sv
// Scoreboard bench for sargantana_icache_mem_ctrl: stimulus queues the
// expected memory-port activity, a negedge monitor pops and compares it.
module tb_sargantana_icache_mem_ctrl;

  logic         clk = 1'b0;
  logic         rst_i;
  logic         flush_req_i;
  logic         flush_done_o;
  logic         busy_o;
  logic         lookup_valid_i;
  logic [6:0]   lookup_idx_i;
  logic         lookup_ready_o;
  logic         refill_valid_i;
  logic [6:0]   refill_idx_i;
  logic [43:0]  refill_tag_i;
  logic [255:0] refill_line_i;
  logic         refill_ready_o;
  logic [3:0]   refill_way_o;
  logic [3:0]   mem_valid_bit_i;
  logic [3:0]   mem_way_req_o;
  logic         mem_we_o;
  logic         mem_valid_bit_o;
  logic [255:0] mem_cline_o;
  logic [43:0]  mem_tag_o;
  logic [6:0]   mem_addr_o;

  always #5 clk = ~clk;

  sargantana_icache_mem_ctrl dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .flush_req_i     (flush_req_i),
    .flush_done_o    (flush_done_o),
    .busy_o          (busy_o),
    .lookup_valid_i  (lookup_valid_i),
    .lookup_idx_i    (lookup_idx_i),
    .lookup_ready_o  (lookup_ready_o),
    .refill_valid_i  (refill_valid_i),
    .refill_idx_i    (refill_idx_i),
    .refill_tag_i    (refill_tag_i),
    .refill_line_i   (refill_line_i),
    .refill_ready_o  (refill_ready_o),
    .refill_way_o    (refill_way_o),
    .mem_valid_bit_i (mem_valid_bit_i),
    .mem_way_req_o   (mem_way_req_o),
    .mem_we_o        (mem_we_o),
    .mem_valid_bit_o (mem_valid_bit_o),
    .mem_cline_o     (mem_cline_o),
    .mem_tag_o       (mem_tag_o),
    .mem_addr_o      (mem_addr_o)
  );

  typedef struct {
    string        name;
    bit           lr;
    bit           rr;
    bit           fd;
    bit           busy;
    bit           we;
    bit           vb;
    bit [3:0]     rw;
    bit [3:0]     way;
    bit [6:0]     addr;
    bit [43:0]    tag;
    bit [255:0]   line;
  } exp_t;

  exp_t q[$];
  exp_t me;
  int   n_total = 0;
  int   n_pass  = 0;
  bit   end_req = 1'b0;
  bit   end_ack = 1'b0;

  function automatic exp_t blank(string n);
    exp_t e;
    e.name = n;
    e.lr = 0; e.rr = 0; e.fd = 0; e.busy = 0; e.we = 0; e.vb = 0;
    e.rw = '0; e.way = '0; e.addr = '0; e.tag = '0; e.line = '0;
    return e;
  endfunction

  task automatic push_lookup(input bit [6:0] idx);
    exp_t e = blank("lookup");
    e.lr = 1; e.way = 4'hF; e.addr = idx;
    q.push_back(e);
  endtask

  task automatic push_refill(input bit [6:0] idx, input bit [43:0] tag,
                             input bit [255:0] line, input bit [3:0] v);
    exp_t e = blank("refill_rd");
    e.busy = 1; e.way = 4'hF; e.addr = idx;
    q.push_back(e);
    e = blank("refill_wr");
    e.busy = 1; e.rr = 1; e.rw = v; e.way = v; e.we = 1; e.vb = 1;
    e.addr = idx; e.tag = tag; e.line = line;
    q.push_back(e);
  endtask

  task automatic push_flush(input int n);
    exp_t e;
    for (int a = 0; a < n; a++) begin
      e = blank("flush");
      e.busy = 1; e.way = 4'hF; e.we = 1; e.addr = 7'(a);
      e.fd = (a == 127);
      q.push_back(e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_refill(input bit [6:0] idx, input bit [43:0] tag,
                           input bit [255:0] line, input bit [3:0] vbits,
                           input bit [3:0] v);
    push_refill(idx, tag, line, v);
    refill_idx_i    = idx;
    refill_tag_i    = tag;
    refill_line_i   = line;
    mem_valid_bit_i = vbits;
    refill_valid_i  = 1'b1;
    step();
    step();
    refill_valid_i = 1'b0;
    step();
  endtask

  always @(negedge clk) begin
    if (!rst_i && (lookup_ready_o || refill_ready_o || flush_done_o ||
                   mem_we_o || (|mem_way_req_o))) begin
      n_total++;
      if (q.size() == 0) begin
        $display("FAIL unexpected: way=%b we=%b addr=%h lr=%b rr=%b fd=%b",
                 mem_way_req_o, mem_we_o, mem_addr_o, lookup_ready_o,
                 refill_ready_o, flush_done_o);
      end else begin
        me = q.pop_front();
        if (lookup_ready_o === me.lr && refill_ready_o === me.rr &&
            flush_done_o === me.fd && busy_o === me.busy &&
            refill_way_o === me.rw && mem_way_req_o === me.way &&
            mem_we_o === me.we && mem_valid_bit_o === me.vb &&
            mem_addr_o === me.addr && mem_tag_o === me.tag &&
            mem_cline_o === me.line) begin
          n_pass++;
        end else begin
          $display({"FAIL %s: got lr=%b rr=%b rw=%b fd=%b busy=%b way=%b ",
                    "we=%b vb=%b addr=%h tag=%h line=%h; want lr=%b rr=%b ",
                    "rw=%b fd=%b busy=%b way=%b we=%b vb=%b addr=%h tag=%h ",
                    "line=%h"}, me.name,
                   lookup_ready_o, refill_ready_o, refill_way_o, flush_done_o,
                   busy_o, mem_way_req_o, mem_we_o, mem_valid_bit_o,
                   mem_addr_o, mem_tag_o, mem_cline_o[31:0],
                   me.lr, me.rr, me.rw, me.fd, me.busy, me.way, me.we, me.vb,
                   me.addr, me.tag, me.line[31:0]);
        end
      end
    end
    if (end_req && !end_ack) begin
      n_total++;
      if (q.size() == 0) n_pass++;
      else $display("FAIL pending: %0d expected outputs missing, next %s",
                    q.size(), q[0].name);
      end_ack = 1'b1;
    end
  end

  initial begin
    rst_i = 1'b1;
    flush_req_i = 1'b0;
    lookup_valid_i = 1'b0;
    lookup_idx_i = '0;
    refill_valid_i = 1'b0;
    refill_idx_i = '0;
    refill_tag_i = '0;
    refill_line_i = '0;
    mem_valid_bit_i = '0;
`ifdef SARGANTANA_ICACHE_FLUSH_ON_RESET_EN
    push_flush(128);
`endif
    step();
    step();
    rst_i = 1'b0;
`ifdef SARGANTANA_ICACHE_FLUSH_ON_RESET_EN
    repeat (128) step();
`endif
    // Zero-cycle lookup grant right out of reset.
    push_lookup(7'h06);
    lookup_valid_i = 1'b1;
    lookup_idx_i = 7'h06;
    step();
    lookup_valid_i = 1'b0;
    step();

    do_refill(7'h14, 44'h67, 256'h12345789, 4'b0000, 4'b0001);

    do_refill(7'h06, 44'h111, 256'hA1, 4'b1111, 4'b0001);
    do_refill(7'h06, 44'h222, 256'hA2, 4'b1111, 4'b0010);
    do_refill(7'h06, 44'h333, 256'hA3, 4'b1111, 4'b0100);
    do_refill(7'h06, 44'h444, 256'hA4, 4'b1111, 4'b1000);
    do_refill(7'h06, 44'h555, 256'hA5, 4'b1111, 4'b0001);

    // Flush with a lookup held high and a second request at cycle 50.
    push_flush(128);
    flush_req_i = 1'b1;
    lookup_valid_i = 1'b1;
    lookup_idx_i = 7'h05;
    step();
    for (int i = 0; i < 128; i++) begin
      flush_req_i = (i == 50);
      if (i == 127) lookup_valid_i = 1'b0;
      step();
    end
    flush_req_i = 1'b0;
    repeat (4) step();

    // Flush request during REFILL_RD waits for the refill write.
    push_refill(7'h2A, 44'hABC, 256'hDEADBEEF, 4'b0100);
    push_flush(128);
    refill_idx_i = 7'h2A;
    refill_tag_i = 44'hABC;
    refill_line_i = 256'hDEADBEEF;
    mem_valid_bit_i = 4'b0011;
    refill_valid_i = 1'b1;
    step();
    flush_req_i = 1'b1;
    step();
    flush_req_i = 1'b0;
    refill_valid_i = 1'b0;
    step();
    repeat (128) step();
    repeat (3) step();

    // Reset while the flush counter is at 40.
    push_flush(40);
    flush_req_i = 1'b1;
    step();
    flush_req_i = 1'b0;
    repeat (40) step();
    rst_i = 1'b1;
`ifdef SARGANTANA_ICACHE_FLUSH_ON_RESET_EN
    push_flush(128);
`endif
    step();
    rst_i = 1'b0;
`ifdef SARGANTANA_ICACHE_FLUSH_ON_RESET_EN
    repeat (128) step();
`endif
    repeat (5) step();

    end_req = 1'b1;
    repeat (3) step();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
